// File: rtl/image_framebuffer_pp.sv
// Ping-pong frame store: a sequential pixel stream fills the back bank while the display
// reads the front bank; the banks swap only on a display frame boundary once the back bank is full.
module image_framebuffer_pp #(
    parameter  int unsigned WIDTH   = 320,
    parameter  int unsigned HEIGHT  = 240,
    parameter  int unsigned PIXEL_W = 12,
    localparam int unsigned DEPTH   = WIDTH * HEIGHT,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               clk_100MHz,
    input  logic               reset,

    input  logic               wr_valid,
    input  logic [PIXEL_W-1:0] wr_pixel,
    output logic               wr_ready,
    input  logic               wr_restart,
    output logic               wr_frame_done,
    output logic               frame_pending,

    input  logic               rd_frame_start,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [PIXEL_W-1:0] rd_pixel,
    output logic               rd_valid,
    output logic               front_bank
);

    localparam int unsigned MEM_WORDS = 2 * DEPTH;
    localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic                 front_bank_q, front_bank_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 frame_pending_q, frame_pending_d;
    logic                 wr_frame_done_q, wr_frame_done_d;
    logic [PIXEL_W-1:0]   rd_pixel_q, rd_pixel_d;
    logic                 rd_valid_q, rd_valid_d;

    logic                 wr_en;
    logic [MEM_AW-1:0]    wr_idx;
    logic [MEM_AW-1:0]    rd_idx;
    logic                 rd_in_range;

    logic [PIXEL_W-1:0]   mem [MEM_WORDS];

    // Back bank occupies the upper half when front is 0, the lower half otherwise.
    always_comb begin
        wr_idx      = (front_bank_q ? MEM_AW'(0) : MEM_AW'(DEPTH)) + MEM_AW'(wr_addr_q);
        rd_idx      = (front_bank_q ? MEM_AW'(DEPTH) : MEM_AW'(0)) + MEM_AW'(rd_addr);
        rd_in_range = (32'(rd_addr) < DEPTH);
    end

    // Write FSM: FILL accepts pixels, FULL waits for the display frame boundary.
    always_comb begin
        state_d         = state_q;
        wr_addr_d       = wr_addr_q;
        front_bank_d    = front_bank_q;
        wr_frame_done_d = 1'b0;
        wr_en           = 1'b0;

        case (state_q)
            S_FILL: begin
                if (wr_restart) begin
                    wr_addr_d = '0;
                end else if (wr_valid) begin
                    wr_en = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d       = '0;
                        state_d         = S_FULL;
                        wr_frame_done_d = 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            S_FULL: begin
                if (rd_frame_start) begin
                    front_bank_d = ~front_bank_q;
                    state_d      = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        wr_ready_d      = (state_d == S_FILL);
        frame_pending_d = (state_d == S_FULL);
    end

    // Read path uses the pre-edge front bank, so a read in a swap cycle returns old data.
    always_comb begin
        rd_pixel_d = rd_pixel_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rd_pixel_d = rd_in_range ? mem[rd_idx] : '0;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q         <= S_FILL;
            wr_addr_q       <= '0;
            front_bank_q    <= 1'b0;
            wr_ready_q      <= 1'b1;
            frame_pending_q <= 1'b0;
            wr_frame_done_q <= 1'b0;
            rd_pixel_q      <= '0;
            rd_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_addr_q       <= wr_addr_d;
            front_bank_q    <= front_bank_d;
            wr_ready_q      <= wr_ready_d;
            frame_pending_q <= frame_pending_d;
            wr_frame_done_q <= wr_frame_done_d;
            rd_pixel_q      <= rd_pixel_d;
            rd_valid_q      <= rd_valid_d;
        end
    end

    // Frame storage is not reset so it maps onto block RAM.
    always_ff @(posedge clk_100MHz) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_pixel;
        end
    end

    assign wr_ready      = wr_ready_q;
    assign frame_pending = frame_pending_q;
    assign wr_frame_done = wr_frame_done_q;
    assign rd_pixel      = rd_pixel_q;
    assign rd_valid      = rd_valid_q;
    assign front_bank    = front_bank_q;

endmodule

// File: tb/tb_image_framebuffer_pp.sv
// Bench for image_framebuffer_pp: directed scenarios plus random traffic against a
// frame-level reference model; a second 6-pixel instance covers out-of-range reads.
module tb_image_framebuffer_pp;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned HEIGHT  = 2;
    localparam int unsigned PIXEL_W = 12;
    localparam int unsigned DEPTH   = WIDTH * HEIGHT;
    localparam int unsigned AW      = 3;
    localparam int unsigned S_DEPTH = 6;

    logic               clk;
    logic               reset;
    logic               wr_valid;
    logic [PIXEL_W-1:0] wr_pixel;
    logic               wr_restart;
    logic               rd_frame_start;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;

    logic               wr_ready, wr_frame_done, frame_pending, rd_valid, front_bank;
    logic [PIXEL_W-1:0] rd_pixel;
    logic               s_wr_ready, s_wr_frame_done, s_frame_pending, s_rd_valid, s_front_bank;
    logic [PIXEL_W-1:0] s_rd_pixel;

    image_framebuffer_pp #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_W(PIXEL_W)) dut (
        .clk_100MHz     (clk),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_pixel       (wr_pixel),
        .wr_ready       (wr_ready),
        .wr_restart     (wr_restart),
        .wr_frame_done  (wr_frame_done),
        .frame_pending  (frame_pending),
        .rd_frame_start (rd_frame_start),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_pixel       (rd_pixel),
        .rd_valid       (rd_valid),
        .front_bank     (front_bank)
    );

    image_framebuffer_pp #(.WIDTH(3), .HEIGHT(2), .PIXEL_W(PIXEL_W)) dut_small (
        .clk_100MHz     (clk),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_pixel       (wr_pixel),
        .wr_ready       (s_wr_ready),
        .wr_restart     (wr_restart),
        .wr_frame_done  (s_wr_frame_done),
        .frame_pending  (s_frame_pending),
        .rd_frame_start (rd_frame_start),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_pixel       (s_rd_pixel),
        .rd_valid       (s_rd_valid),
        .front_bank     (s_front_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    // Reference model: two frame arrays, which one is shown, and how far the next frame has got.
    int                 m_front;
    bit                 m_pending;
    int                 m_fill;
    logic [PIXEL_W-1:0] m_store [2][DEPTH];
    bit                 m_known [2][DEPTH];
    bit                 m_done;
    bit                 m_rd_valid;
    logic [PIXEL_W-1:0] m_rd_pixel;
    bit                 m_pix_known;

    logic [PIXEL_W-1:0] spix [S_DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int a;
        if (reset) begin
            m_front     = 0;
            m_pending   = 1'b0;
            m_fill      = 0;
            m_done      = 1'b0;
            m_rd_valid  = 1'b0;
            m_rd_pixel  = '0;
            m_pix_known = 1'b1;
            return;
        end
        a          = int'(rd_addr);
        m_rd_valid = rd_en;
        if (rd_en) begin
            if (a < int'(DEPTH)) begin
                m_rd_pixel  = m_store[m_front][a];
                m_pix_known = m_known[m_front][a];
            end else begin
                m_rd_pixel  = '0;
                m_pix_known = 1'b1;
            end
        end
        m_done = 1'b0;
        if (!m_pending) begin
            if (wr_restart) begin
                m_fill = 0;
            end else if (wr_valid) begin
                m_store[1 - m_front][m_fill] = wr_pixel;
                m_known[1 - m_front][m_fill] = 1'b1;
                m_fill++;
                if (m_fill == int'(DEPTH)) begin
                    m_fill    = 0;
                    m_pending = 1'b1;
                    m_done    = 1'b1;
                end
            end
        end else if (rd_frame_start) begin
            m_front   = 1 - m_front;
            m_pending = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("wr_ready",      32'(wr_ready),      32'(!m_pending));
        check("frame_pending", 32'(frame_pending), 32'(m_pending));
        check("front_bank",    32'(front_bank),    32'(m_front));
        check("wr_frame_done", 32'(wr_frame_done), 32'(m_done));
        check("rd_valid",      32'(rd_valid),      32'(m_rd_valid));
        if (m_pix_known) begin
            check("rd_pixel", 32'(rd_pixel), 32'(m_rd_pixel));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [PIXEL_W-1:0] p, input bit rs,
                         input bit fs, input bit re, input logic [AW-1:0] a);
        wr_valid       = v;
        wr_pixel       = p;
        wr_restart     = rs;
        rd_frame_start = fs;
        rd_en          = re;
        rd_addr        = a;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_step();
        check_outputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic stream(input int n, input logic [PIXEL_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + PIXEL_W'(i), 1'b0, 1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic swap();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic read_all();
        for (int a = 0; a < int'(DEPTH); a++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(a));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_front  = 0;
        m_pending = 1'b0;
        m_fill   = 0;
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < int'(DEPTH); a++) begin
                m_known[b][a] = 1'b0;
                m_store[b][a] = '0;
            end
        end
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        apply_reset();

        // Small instance: 6-pixel frame, then reads up to address 7 (6 and 7 are out of range).
        for (int i = 0; i < int'(S_DEPTH); i++) begin
            spix[i] = PIXEL_W'($urandom);
            drive(1'b1, spix[i], 1'b0, 1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        check("s_frame_pending", 32'(s_frame_pending), 32'd1);
        check("s_wr_ready", 32'(s_wr_ready), 32'd0);
        swap();
        check("s_front_bank", 32'(s_front_bank), 32'd1);
        check("s_wr_ready_after_swap", 32'(s_wr_ready), 32'd1);
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(a));
            tick();
            check("s_rd_valid", 32'(s_rd_valid), 32'd1);
            check("s_rd_pixel", 32'(s_rd_pixel), (a < int'(S_DEPTH)) ? 32'(spix[a]) : 32'd0);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        apply_reset();

        // First frame 0x001..0x008 with wr_valid held into FULL, then swap and read back.
        stream(8, 12'h001);
        drive(1'b1, 12'hEEE, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        check("held_front_bank", 32'(front_bank), 32'd0);
        swap();
        read_all();

        // Restart discards the partial frame and the pixel presented with it.
        stream(3, PIXEL_W'($urandom));
        drive(1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0, '0);
        tick();
        stream(8, 12'h101);
        swap();
        read_all();

        // Last pixel coincides with rd_frame_start: swap deferred to the next pulse.
        stream(7, 12'h400);
        drive(1'b1, 12'h407, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        swap();
        read_all();

        // Back-to-back reads straddling a swap edge, then a held rd_pixel.
        stream(8, 12'h200);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd2);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 3'd3);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd3);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd5);
        tick();
        tick();

        // Reset mid-frame, then a full frame lands in bank 1.
        stream(5, 12'h350);
        apply_reset();
        stream(8, 12'h300);
        swap();
        read_all();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, PIXEL_W'($urandom), $urandom_range(0, 31) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, AW'($urandom));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
